// File: rtl/wb_rr_arbiter_pkg.sv
// Shared widths, writeback entry payload and sequence-number age compare
// for the writeback round-robin arbiter.
package wb_rr_arbiter_pkg;

    localparam int unsigned num_pipes      = 4;
    localparam int unsigned seq_num_bits   = 5;
    localparam int unsigned phys_addr_bits = 6;
    localparam int unsigned xlen           = 32;

    typedef struct packed {
        logic [seq_num_bits-1:0]   seq_num;
        logic [xlen-1:0]           pc;
        logic [phys_addr_bits-1:0] waddr;
        logic [xlen-1:0]           wdata;
        logic                      wen;
    } wb_entry_t;

    // Age is the wrapped distance from the oldest in-flight instruction.
    function automatic logic is_younger(input logic [seq_num_bits-1:0] seq,
                                        input logic [seq_num_bits-1:0] ref_seq,
                                        input logic [seq_num_bits-1:0] head);
        logic [seq_num_bits-1:0] age_seq;
        logic [seq_num_bits-1:0] age_ref;
        age_seq = seq - head;
        age_ref = ref_seq - head;
        return age_seq > age_ref;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Execute-pipe completion bus, writeback output and squash/head inputs
// seen by the writeback arbiter.
interface wb_rr_arbiter_if
    import wb_rr_arbiter_pkg::*;
#(
    parameter int unsigned p_num_pipes      = num_pipes,
    parameter int unsigned p_seq_num_bits   = seq_num_bits,
    parameter int unsigned p_phys_addr_bits = phys_addr_bits
);

    logic [p_num_pipes-1:0]                  ex_val;
    logic [p_num_pipes-1:0]                  ex_rdy;
    logic [p_num_pipes*p_seq_num_bits-1:0]   ex_seq_num;
    logic [p_num_pipes*32-1:0]               ex_pc;
    logic [p_num_pipes*p_phys_addr_bits-1:0] ex_waddr;
    logic [p_num_pipes*32-1:0]               ex_wdata;
    logic [p_num_pipes-1:0]                  ex_wen;

    logic                        w_val;
    logic                        w_rdy;
    logic [p_seq_num_bits-1:0]   w_seq_num;
    logic [31:0]                 w_pc;
    logic [p_phys_addr_bits-1:0] w_waddr;
    logic [31:0]                 w_wdata;
    logic                        w_wen;

    logic [p_seq_num_bits-1:0]   head_seq_num;
    logic                        squash_val;
    logic [p_seq_num_bits-1:0]   squash_seq_num;

    // Arbiter side
    modport slave (
        input  ex_val, ex_seq_num, ex_pc, ex_waddr, ex_wdata, ex_wen,
        input  w_rdy, head_seq_num, squash_val, squash_seq_num,
        output ex_rdy, w_val, w_seq_num, w_pc, w_waddr, w_wdata, w_wen
    );

    // Pipes / writeback / squash source side
    modport master (
        output ex_val, ex_seq_num, ex_pc, ex_waddr, ex_wdata, ex_wen,
        output w_rdy, head_seq_num, squash_val, squash_seq_num,
        input  ex_rdy, w_val, w_seq_num, w_pc, w_waddr, w_wdata, w_wen
    );

endinterface

// File: rtl/wb_rr_arbiter_rr_arb.sv
// Generic round-robin priority pick: first request at or after ptr,
// wrapping, returned as a one-hot grant plus its index.
module rr_arb_n #(
    parameter  int unsigned p_num_width = 4,
    localparam int unsigned idx_w       = (p_num_width > 1) ? $clog2(p_num_width) : 1
) (
    input  logic [p_num_width-1:0] req,
    input  logic [idx_w-1:0]       ptr,
    output logic [p_num_width-1:0] gnt_c,
    output logic [idx_w-1:0]       gnt_idx_c,
    output logic                   gnt_val_c
);

    function automatic logic [idx_w-1:0] wrap_idx(input logic [idx_w-1:0] base,
                                                  input int unsigned off);
        return idx_w'((32'(base) + off) % p_num_width);
    endfunction

    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_val_c = 1'b0;
        for (int unsigned k = 0; k < p_num_width; k++) begin
            if (!gnt_val_c && req[wrap_idx(ptr, k)]) begin
                gnt_val_c                = 1'b1;
                gnt_idx_c                = wrap_idx(ptr, k);
                gnt_c[wrap_idx(ptr, k)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter from the execute pipes onto the single writeback path,
// with a one-entry output register and wrong-path squash filtering.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int unsigned p_num_pipes      = num_pipes,
    parameter int unsigned p_seq_num_bits   = seq_num_bits,
    parameter int unsigned p_phys_addr_bits = phys_addr_bits
) (
    input logic            clk,
    input logic            rst,
    wb_rr_arbiter_if.slave bus
);

    localparam int unsigned idx_w = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

    logic [idx_w-1:0]       ptr;
    logic                   val_q;
    wb_entry_t              entry_q;
    wb_entry_t              grant_entry_c;
    logic [p_num_pipes-1:0] req_c;
    logic [p_num_pipes-1:0] gnt_c;
    logic [idx_w-1:0]       gnt_idx_c;
    logic                   gnt_val_c;
    logic                   reg_kill_c;
    logic                   out_val_c;
    logic                   free_c;
    logic                   grant_kill_c;
    logic                   load_c;

    // A squashed held entry is hidden immediately, so it also frees the register.
    assign reg_kill_c = bus.squash_val &&
                        is_younger(entry_q.seq_num, bus.squash_seq_num, bus.head_seq_num);
    assign out_val_c  = val_q && !reg_kill_c;
    assign free_c     = !out_val_c || bus.w_rdy;
    assign req_c      = bus.ex_val & {p_num_pipes{free_c && rst}};

    rr_arb_n #(.p_num_width(p_num_pipes)) u_rr_arb (
        .req       (req_c),
        .ptr       (ptr),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c),
        .gnt_val_c (gnt_val_c)
    );

    always_comb begin
        grant_entry_c.seq_num = seq_num_bits'(bus.ex_seq_num[32'(gnt_idx_c)*p_seq_num_bits +: p_seq_num_bits]);
        grant_entry_c.pc      = bus.ex_pc[32'(gnt_idx_c)*32 +: 32];
        grant_entry_c.waddr   = phys_addr_bits'(bus.ex_waddr[32'(gnt_idx_c)*p_phys_addr_bits +: p_phys_addr_bits]);
        grant_entry_c.wdata   = bus.ex_wdata[32'(gnt_idx_c)*32 +: 32];
        grant_entry_c.wen     = bus.ex_wen[gnt_idx_c];
    end

    // Wrong-path grants still release the pipe but never reach the register.
    assign grant_kill_c = bus.squash_val &&
                          is_younger(grant_entry_c.seq_num, bus.squash_seq_num, bus.head_seq_num);
    assign load_c       = gnt_val_c && !grant_kill_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            val_q   <= 1'b0;
            entry_q <= '0;
        end else begin
            if (gnt_val_c) begin
                ptr <= (gnt_idx_c == idx_w'(p_num_pipes - 1)) ? '0 : idx_w'(gnt_idx_c + 1'b1);
            end
            if (load_c) begin
                entry_q <= grant_entry_c;
                val_q   <= 1'b1;
            end else if (free_c) begin
                val_q   <= 1'b0;
            end
        end
    end

    assign bus.ex_rdy    = gnt_c;
    assign bus.w_val     = out_val_c;
    assign bus.w_seq_num = p_seq_num_bits'(entry_q.seq_num);
    assign bus.w_pc      = entry_q.pc;
    assign bus.w_waddr   = p_phys_addr_bits'(entry_q.waddr);
    assign bus.w_wdata   = entry_q.wdata;
    assign bus.w_wen     = entry_q.wen;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;

    localparam int np = 4;
    localparam int sb = 5;
    localparam int ab = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_d = 1'b0;
    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.p_num_pipes(np), .p_seq_num_bits(sb), .p_phys_addr_bits(ab)) bus ();

    wb_rr_arbiter #(.p_num_pipes(np), .p_seq_num_bits(sb), .p_phys_addr_bits(ab)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // stimulus
    logic [np-1:0] in_val;
    logic [sb-1:0] in_seq   [np];
    logic [31:0]   in_pc    [np];
    logic [ab-1:0] in_waddr [np];
    logic [31:0]   in_wdata [np];
    logic          in_wen   [np];
    logic          in_wrdy;
    logic [sb-1:0] in_head;
    logic          in_sq;
    logic [sb-1:0] in_sqseq;

    // model state
    int            m_ptr;
    bit            m_val;
    logic [sb-1:0] m_seq;
    logic [31:0]   m_pc;
    logic [ab-1:0] m_waddr;
    logic [31:0]   m_wdata;
    logic          m_wen;
    int            m_g;
    bit            m_free;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit younger(input int x, input int s, input int h);
        int m = (1 << sb) - 1;
        return ((x - h) & m) > ((s - h) & m);
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_val = 0; m_seq = '0; m_pc = '0; m_waddr = '0; m_wdata = '0; m_wen = 1'b0;
    endtask

    task automatic apply();
        for (int i = 0; i < np; i++) begin
            bus.ex_seq_num[i*sb +: sb] = in_seq[i];
            bus.ex_pc[i*32 +: 32]      = in_pc[i];
            bus.ex_waddr[i*ab +: ab]   = in_waddr[i];
            bus.ex_wdata[i*32 +: 32]   = in_wdata[i];
            bus.ex_wen[i]              = in_wen[i];
        end
        bus.ex_val         = in_val;
        bus.w_rdy          = in_wrdy;
        bus.head_seq_num   = in_head;
        bus.squash_val     = in_sq;
        bus.squash_seq_num = in_sqseq;
    endtask

    // Compute what the outputs must be this cycle and compare.
    task automatic eval();
        bit            exp_w;
        logic [np-1:0] exp_rdy;
        exp_w   = m_val && !(in_sq && younger(m_seq, in_sqseq, in_head));
        m_free  = !exp_w || in_wrdy;
        m_g     = -1;
        exp_rdy = '0;
        if (rst && m_free) begin
            for (int k = 0; k < np; k++) begin
                int i = (m_ptr + k) % np;
                if (m_g < 0 && in_val[i]) m_g = i;
            end
        end
        if (m_g >= 0) exp_rdy[m_g] = 1'b1;
        check("ex_rdy",    bus.ex_rdy,    exp_rdy);
        check("w_val",     bus.w_val,     exp_w);
        check("w_seq_num", bus.w_seq_num, m_seq);
        check("w_pc",      bus.w_pc,      m_pc);
        check("w_waddr",   bus.w_waddr,   m_waddr);
        check("w_wdata",   bus.w_wdata,   m_wdata);
        check("w_wen",     bus.w_wen,     m_wen);
    endtask

    task automatic update();
        if (!rst) begin
            model_reset();
        end else if (m_g >= 0) begin
            m_ptr = (m_g + 1) % np;
            if (in_sq && younger(in_seq[m_g], in_sqseq, in_head)) begin
                m_val = 0;
            end else begin
                m_val   = 1;
                m_seq   = in_seq[m_g];
                m_pc    = in_pc[m_g];
                m_waddr = in_waddr[m_g];
                m_wdata = in_wdata[m_g];
                m_wen   = in_wen[m_g];
            end
        end else if (m_free) begin
            m_val = 0;
        end
    endtask

    task automatic start_cycle();
        @(negedge clk);
        rst = rst_d;
        apply();
        #1;
        eval();
    endtask

    task automatic end_cycle();
        @(posedge clk);
        update();
    endtask

    task automatic cycle();
        start_cycle();
        end_cycle();
    endtask

    initial begin
        model_reset();
        in_val = '0; in_wrdy = 1'b0; in_head = '0; in_sq = 1'b0; in_sqseq = '0;
        for (int i = 0; i < np; i++) begin
            in_seq[i]   = sb'(10 + i);
            in_pc[i]    = 32'h1000 + 32'(i * 4);
            in_waddr[i] = ab'(i + 1);
            in_wdata[i] = 32'hA000_0000 + 32'(i);
            in_wen[i]   = 1'b1;
        end
        apply();

        // reset: no grant even with requests present
        cycle();
        in_val = 4'hF;
        start_cycle();
        check("rst_ex_rdy", bus.ex_rdy, 4'h0);
        check("rst_w_val",  bus.w_val,  1'b0);
        check("rst_w_pc",   bus.w_pc,   32'h0);
        end_cycle();
        rst_d = 1'b1;

        // fairness
        in_wrdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            logic [np-1:0] er;
            er = 4'(1 << (c % 4));
            start_cycle();
            check("fair_rdy", bus.ex_rdy, er);
            if (c > 0) check("fair_seq", bus.w_seq_num, 5'(10 + (c - 1) % 4));
            end_cycle();
        end

        // backpressure
        in_wrdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            start_cycle();
            check("bp_rdy", bus.ex_rdy,    4'h0);
            check("bp_val", bus.w_val,     1'b1);
            check("bp_seq", bus.w_seq_num, 5'd10);
            end_cycle();
        end
        in_wrdy = 1'b1;
        start_cycle();
        check("bp_drain_rdy", bus.ex_rdy,    4'b0010);
        check("bp_drain_seq", bus.w_seq_num, 5'd10);
        end_cycle();
        in_val = '0;
        start_cycle();
        check("bp_next_seq", bus.w_seq_num, 5'd11);
        end_cycle();

        // registered squash: seq 6 younger than 4 (head 0) is killed
        in_val = 4'b0001; in_seq[0] = 5'd6; in_wrdy = 1'b0;
        start_cycle();
        check("sq_load_rdy", bus.ex_rdy, 4'b0001);
        end_cycle();
        in_val = '0; in_sq = 1'b1; in_sqseq = 5'd4; in_wrdy = 1'b1;
        start_cycle();
        check("sq_kill_now", bus.w_val, 1'b0);
        end_cycle();
        in_sq = 1'b0;
        start_cycle();
        check("sq_kill_next", bus.w_val, 1'b0);
        end_cycle();
        // seq 2 is older than 4 and survives
        in_val = 4'b0001; in_seq[0] = 5'd2; in_wrdy = 1'b0;
        cycle();
        in_val = '0; in_sq = 1'b1;
        start_cycle();
        check("sq_keep_val", bus.w_val,     1'b1);
        check("sq_keep_seq", bus.w_seq_num, 5'd2);
        end_cycle();
        in_sq = 1'b0; in_wrdy = 1'b1;
        start_cycle();
        check("sq_keep_val2", bus.w_val, 1'b1);
        end_cycle();

        // squash on grant across the wrap: head 30, seq 1 younger than 31
        in_head = 5'd30; in_val = 4'b0100; in_seq[2] = 5'd1; in_sq = 1'b1; in_sqseq = 5'd31;
        start_cycle();
        check("sog_rdy", bus.ex_rdy, 4'b0100);
        end_cycle();
        in_sq = 1'b0; in_val = 4'hF;
        start_cycle();
        check("sog_val",     bus.w_val,  1'b0);
        check("sog_ptr_rdy", bus.ex_rdy, 4'b1000);
        end_cycle();

        // single requester
        in_head = 5'd0; in_val = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            start_cycle();
            check("single_rdy", bus.ex_rdy, 4'b1000);
            end_cycle();
        end

        // reset mid-stream while holding seq 3
        in_val = 4'hF; in_seq[0] = 5'd3;
        start_cycle();
        check("mid_pre_rdy", bus.ex_rdy, 4'b0001);
        end_cycle();
        in_wrdy = 1'b0;
        start_cycle();
        check("mid_hold_seq", bus.w_seq_num, 5'd3);
        #2 rst = 1'b0; rst_d = 1'b0;
        #1;
        check("mid_rst_val", bus.w_val,     1'b0);
        check("mid_rst_seq", bus.w_seq_num, 5'd0);
        check("mid_rst_rdy", bus.ex_rdy,    4'h0);
        end_cycle();
        cycle();
        rst_d = 1'b1; in_wrdy = 1'b1;
        start_cycle();
        check("post_rst_rdy", bus.ex_rdy, 4'b0001);
        end_cycle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_val  = 4'($urandom);
            in_wrdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) in_head = sb'($urandom);
            in_sq    = ($urandom_range(0, 9) < 2);
            in_sqseq = sb'($urandom);
            for (int i = 0; i < np; i++) begin
                in_seq[i]   = sb'($urandom);
                in_pc[i]    = $urandom;
                in_waddr[i] = ab'($urandom);
                in_wdata[i] = $urandom;
                in_wen[i]   = 1'($urandom);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
